// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - streams a burst of RAM words out over a ready/valid interface
// A registered output stage backed by a 2-entry buffer absorbs the RAM's two-cycle read loop.
module ram_burst_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [AW-1:0]    i_base_addr,
  input  logic [AW:0]      i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_rd_en,
  output logic [AW-1:0]    o_rd_addr,
  input  logic [WIDTH-1:0] i_rd_data,
  input  logic             i_rd_dv,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_last,
  input  logic             i_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);

  state_t           state;
  logic [AW:0]      rd_left;
  logic [AW:0]      rx_left;
  logic             rd_inflight;
  logic [WIDTH-1:0] buf_data [2];
  logic [1:0]       buf_last;
  logic             buf_wp;
  logic             buf_rp;
  logic [1:0]       buf_cnt;

  logic          pop;
  logic          push;
  logic          push_last;
  logic          load_out;
  logic          buf_rd;
  logic          buf_wr;
  logic          can_issue;
  logic [2:0]    occ;
  logic [AW-1:0] next_addr;

  assign pop       = o_valid & i_ready;
  // Read data is only accepted when a read was actually issued the cycle before.
  assign push      = i_rd_dv & rd_inflight;
  assign push_last = (rx_left == LEN_ONE);
  assign load_out  = !o_valid || pop;
  assign buf_rd    = load_out && (buf_cnt != 2'd0);
  assign buf_wr    = push && !(load_out && (buf_cnt == 2'd0));
  assign next_addr = (o_rd_addr == LAST_ADDR) ? '0 : o_rd_addr + ADDR_ONE;

  // Credit spans the presented beat, the buffer and both RAM pipeline stages;
  // three slots sustain one beat per cycle without ever overrunning storage.
  assign occ       = 3'(o_valid) + 3'(buf_cnt) + 3'(o_rd_en) + 3'(rd_inflight);
  assign can_issue = (state == ISSUE) && (rd_left != '0) && ((occ - 3'(pop)) < 3'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr   <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      rd_left     <= '0;
      rx_left     <= '0;
      rd_inflight <= 1'b0;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_last    <= '0;
      buf_wp      <= 1'b0;
      buf_rp      <= 1'b0;
      buf_cnt     <= '0;
    end else begin
      o_done      <= 1'b0;
      o_rd_en     <= 1'b0;
      rd_inflight <= o_rd_en;
      if (push) rx_left <= rx_left - LEN_ONE;

      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_len == '0) begin
              o_done <= 1'b1;
            end else begin
              state     <= ISSUE;
              o_busy    <= 1'b1;
              o_rd_en   <= 1'b1;
              o_rd_addr <= i_base_addr;
              rd_left   <= i_len - LEN_ONE;
              rx_left   <= i_len;
            end
          end
        end
        ISSUE: begin
          if (can_issue) begin
            o_rd_en   <= 1'b1;
            o_rd_addr <= next_addr;
            rd_left   <= rd_left - LEN_ONE;
          end
          if ((rd_left == '0) || (can_issue && (rd_left == LEN_ONE))) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && o_last) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      if (buf_wr) begin
        buf_data[buf_wp] <= i_rd_data;
        buf_last[buf_wp] <= push_last;
        buf_wp           <= ~buf_wp;
      end
      if (buf_rd) buf_rp <= ~buf_rp;
      buf_cnt <= buf_cnt + 2'(buf_wr) - 2'(buf_rd);

      // Older buffered beats always take the output stage ahead of fresh RAM data.
      if (load_out) begin
        if (buf_rd) begin
          o_valid <= 1'b1;
          o_data  <= buf_data[buf_rp];
          o_last  <= buf_last[buf_rp];
        end else if (push) begin
          o_valid <= 1'b1;
          o_data  <= i_rd_data;
          o_last  <= push_last;
        end else begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// tb/tb_ram_burst_reader.sv - directed bench for ram_burst_reader with a one-cycle RAM model
module tb_ram_burst_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW-1:0] i_base_addr = '0;
  logic [AW:0]   i_len = '0;
  logic          o_busy;
  logic          o_done;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic [WIDTH-1:0] i_rd_data;
  logic          i_rd_dv;
  logic [WIDTH-1:0] o_data;
  logic          o_valid;
  logic          o_last;
  logic          i_ready = 1'b0;

  logic          ram_dv_q = 1'b0;
  logic          inj_dv = 1'b0;
  logic [7:0]    ram_q = '0;

  int vectors = 0;
  int miscompares = 0;

  ram_burst_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_len(i_len), .o_busy(o_busy), .o_done(o_done), .o_rd_en(o_rd_en),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .i_rd_dv(i_rd_dv), .o_data(o_data),
    .o_valid(o_valid), .o_last(o_last), .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [7:0] mem_val(input logic [7:0] a);
    return a * 8'd7 + 8'd3;
  endfunction

  always @(posedge i_clk) begin
    ram_dv_q <= o_rd_en;
    if (o_rd_en) ram_q <= mem_val(o_rd_addr);
  end
  assign i_rd_dv   = ram_dv_q | inj_dv;
  assign i_rd_data = ram_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_burst(input logic [7:0] base, input logic [8:0] len, input int mode,
                           input int restart, output logic [7:0] first_data,
                           output logic [7:0] last_data);
    int nrd, nbeat, ndone, first_rd, first_vld, last_beat_cyc, done_cyc;
    logic stall, pl;
    logic [7:0] pd, ea;
    nrd = 0; nbeat = 0; ndone = 0; first_rd = 0; first_vld = 0;
    last_beat_cyc = 0; done_cyc = 0; stall = 1'b0; pl = 1'b0; pd = '0;
    first_data = '0; last_data = '0;
    i_start = 1'b1; i_base_addr = base; i_len = len;
    step();
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (cyc == restart) begin
        i_start = 1'b1; i_base_addr = 8'h80; i_len = 9'd3;
      end else begin
        i_start = 1'b0;
      end
      i_ready = (mode == 0) ? 1'b1 : 1'(cyc % 2);
      if (cyc == 1) check("busy_after_start", o_busy, 1);
      if (o_rd_en) begin
        ea = base + nrd[7:0];
        check("rd_addr", o_rd_addr, ea);
        if (nrd == 0) first_rd = cyc;
        nrd++;
      end
      if (o_valid && first_vld == 0) first_vld = cyc;
      if (stall) check("stall_hold", {o_valid, o_last, o_data}, {1'b1, pl, pd});
      stall = o_valid && !i_ready;
      pd = o_data;
      pl = o_last;
      if (o_valid && i_ready) begin
        ea = base + nbeat[7:0];
        check("beat_data", o_data, mem_val(ea));
        check("beat_last", o_last, (nbeat == int'(len) - 1));
        if (nbeat == 0) first_data = o_data;
        last_data = o_data;
        last_beat_cyc = cyc;
        nbeat++;
      end
      if (o_done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (done_cyc != 0 && cyc >= done_cyc + 3) break;
      step();
    end
    i_start = 1'b0;
    check("reads_issued", nrd, int'(len));
    check("beats", nbeat, int'(len));
    check("done_pulses", ndone, 1);
    check("done_timing", done_cyc, last_beat_cyc + 1);
    check("idle_after", o_busy, 0);
    if (mode == 0) begin
      check("first_rd_cyc", first_rd, 1);
      check("first_vld_cyc", first_vld, 3);
      check("beat_rate", last_beat_cyc, 2 + int'(len));
    end
  endtask

  initial begin
    logic [7:0] fd, ld;
    int nb, bad;
    step();
    step();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_rd_en", o_rd_en, 0);
    check("rst_valid", o_valid, 0);
    check("rst_last", o_last, 0);
    check("rst_rd_addr", o_rd_addr, 0);
    check("rst_data", o_data, 0);
    i_rst_n = 1'b1;
    step();

    run_burst(8'h10, 9'd4, 0, 0, fd, ld);
    check("b10_first", fd, 8'h73);
    check("b10_last", ld, 8'h88);

    run_burst(8'hFE, 9'd4, 0, 0, fd, ld);
    check("wrap_first", fd, 8'hF5);
    check("wrap_last", ld, 8'h0A);

    run_burst(8'h05, 9'd8, 1, 0, fd, ld);
    check("toggle_first", fd, 8'h26);
    check("toggle_last", ld, 8'h57);

    i_start = 1'b1; i_base_addr = 8'h33; i_len = 9'd0;
    step();
    i_start = 1'b0;
    check("len0_done", o_done, 1);
    check("len0_busy", o_busy, 0);
    check("len0_rd_en", o_rd_en, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (o_done || o_busy || o_rd_en || o_valid) bad++;
    end
    check("len0_quiet", bad, 0);

    run_burst(8'h40, 9'd5, 0, 2, fd, ld);
    check("restart_first", fd, 8'hC3);
    check("restart_last", ld, 8'hDF);

    i_ready = 1'b1;
    i_start = 1'b1; i_base_addr = 8'h20; i_len = 9'd6;
    step();
    i_start = 1'b0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_valid && nb == 2) break;
      if (o_valid) nb++;
      step();
    end
    check("rst_at_third_beat", {o_valid, o_data}, {1'b1, mem_val(8'h22)});
    i_rst_n = 1'b0;
    #1;
    check("midrst_outputs", {o_busy, o_done, o_rd_en, o_valid, o_last, o_rd_addr, o_data}, 0);
    step();
    step();
    i_rst_n = 1'b1;
    inj_dv = 1'b1;
    step();
    inj_dv = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid || o_done || o_busy || o_rd_en) bad++;
      step();
    end
    check("post_rst_quiet", bad, 0);

    run_burst(8'h00, 9'd2, 0, 0, fd, ld);
    check("post_rst_first", fd, 8'h03);
    check("post_rst_last", ld, 8'h0A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
